// File: rtl/addr_trans_tlb_if.sv
// Request/response handshake bundle between the AGU, the address translator and dcache.
interface addr_trans_tlb_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_vaddr;
   logic        req_store;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_paddr;
   logic        resp_uncache;
   logic [2:0]  resp_exc;

   modport master (
      output req_valid, req_vaddr, req_store, resp_ready,
      input  req_ready, resp_valid, resp_paddr, resp_uncache, resp_exc
   );

   modport slave (
      input  req_valid, req_vaddr, req_store, resp_ready,
      output req_ready, resp_valid, resp_paddr, resp_uncache, resp_exc
   );
endinterface

// File: rtl/addr_trans_tlb.sv
// Data-side LA32 address translation: DMW0/DMW1 windows in front of a fully-associative
// TLB, one registered stage behind a valid/ready handshake, and a saturating miss counter.
module addr_trans_tlb #(
   parameter int unsigned TLB_ENTRIES = 8,
   parameter logic [15:0] UNCACHE_HI  = 16'hbfaf,
   parameter int unsigned CNT_W       = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   addr_trans_tlb_if.slave                bus,
   input  logic                           csr_da,
   input  logic                           csr_pg,
   input  logic [1:0]                     csr_plv,
   input  logic [9:0]                     csr_asid,
   input  logic [31:0]                    csr_dmw0,
   input  logic [31:0]                    csr_dmw1,
   input  logic                           tlb_we,
   input  logic [$clog2(TLB_ENTRIES)-1:0] tlb_widx,
   input  logic [19:0]                    tlb_wvppn,
   input  logic [19:0]                    tlb_wppn,
   input  logic [9:0]                     tlb_wasid,
   input  logic                           tlb_wg,
   input  logic                           tlb_wv,
   input  logic                           tlb_wd,
   input  logic [1:0]                     tlb_wmat,
   input  logic [1:0]                     tlb_wplv,
   input  logic                           tlb_inv_all,
   output logic [CNT_W-1:0]               perf_miss_cnt
);
   localparam int unsigned IDX_W = $clog2(TLB_ENTRIES);

   typedef enum logic [2:0] {
      EXC_NONE = 3'd0,
      EXC_TLBR = 3'd1,
      EXC_INV  = 3'd2,
      EXC_PPI  = 3'd3,
      EXC_PME  = 3'd4
   } exc_e;

   typedef struct packed {
      logic [19:0] vppn;
      logic [19:0] ppn;
      logic [9:0]  asid;
      logic        g;
      logic        d;
      logic [1:0]  mat;
      logic [1:0]  plv;
   } tlb_entry_t;

   tlb_entry_t             tlb_q [TLB_ENTRIES];
   logic [TLB_ENTRIES-1:0] tlb_v_q, tlb_v_d;

   logic             resp_valid_q, resp_valid_d;
   logic [31:0]      resp_paddr_q, resp_paddr_d;
   logic             resp_uncache_q, resp_uncache_d;
   exc_e             resp_exc_q, resp_exc_d;
   logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

   logic             pg_mode, req_fire;
   logic             hit;
   logic [IDX_W-1:0] hit_idx;
   tlb_entry_t       hit_entry;
   logic             hit_v;
   logic [31:0]      xl_paddr;
   logic             xl_uncache;
   exc_e             xl_exc;

   logic unused_dmw;
   assign unused_dmw = ^{csr_dmw0[28], csr_dmw0[24:6], csr_dmw0[2:1],
                         csr_dmw1[28], csr_dmw1[24:6], csr_dmw1[2:1]};

   function automatic logic dmw_hit(input logic [31:0] dmw, input logic [1:0] plv,
                                    input logic [2:0] vseg);
      return ((dmw[0] && plv == 2'd0) || (dmw[3] && plv == 2'd3)) && (vseg == dmw[31:29]);
   endfunction

   assign pg_mode       = !csr_da && csr_pg;
   assign bus.req_ready = !resp_valid_q || bus.resp_ready;
   assign req_fire      = bus.req_valid && bus.req_ready;

   // Descending scan so the lowest matching index is the one left standing.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      hit     = 1'b0;
      hit_idx = '0;
      for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
         if (tlb_q[i].vppn == bus.req_vaddr[31:12] &&
             (tlb_q[i].g || tlb_q[i].asid == csr_asid)) begin
            hit     = 1'b1;
            hit_idx = IDX_W'(i);
         end
      end
   end

   assign hit_entry = tlb_q[hit_idx];
   assign hit_v     = tlb_v_q[hit_idx];

   always_comb begin
      xl_paddr   = bus.req_vaddr;
      xl_uncache = 1'b0;
      xl_exc     = EXC_NONE;
      if (pg_mode) begin
         if (dmw_hit(csr_dmw0, csr_plv, bus.req_vaddr[31:29])) begin
            xl_paddr   = {csr_dmw0[27:25], bus.req_vaddr[28:0]};
            xl_uncache = (csr_dmw0[5:4] == 2'b00);
         end else if (dmw_hit(csr_dmw1, csr_plv, bus.req_vaddr[31:29])) begin
            xl_paddr   = {csr_dmw1[27:25], bus.req_vaddr[28:0]};
            xl_uncache = (csr_dmw1[5:4] == 2'b00);
         end else if (!hit) begin
            xl_exc = EXC_TLBR;
         end else if (!hit_v) begin
            xl_exc = EXC_INV;
         end else if (csr_plv > hit_entry.plv) begin
            xl_exc = EXC_PPI;
         end else if (bus.req_store && !hit_entry.d) begin
            xl_exc = EXC_PME;
         end else begin
            xl_paddr   = {hit_entry.ppn, bus.req_vaddr[11:0]};
            xl_uncache = (hit_entry.mat == 2'b00);
         end
      end
      if (xl_exc == EXC_NONE && bus.req_vaddr[31:16] == UNCACHE_HI) xl_uncache = 1'b1;
   end

   always_comb begin
      resp_valid_d   = resp_valid_q;
      resp_paddr_d   = resp_paddr_q;
      resp_uncache_d = resp_uncache_q;
      resp_exc_d     = resp_exc_q;
      miss_cnt_d     = miss_cnt_q;
      if (req_fire) begin
         resp_valid_d   = 1'b1;
         resp_paddr_d   = xl_paddr;
         resp_uncache_d = xl_uncache;
         resp_exc_d     = xl_exc;
         if (xl_exc == EXC_TLBR && miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_W'(1);
      end else if (bus.resp_ready) begin
         resp_valid_d = 1'b0;
      end
   end

   // Invalidate-all first, then the single write, so the written index keeps its new V.
   always_comb begin
      tlb_v_d = tlb_v_q;
      if (tlb_inv_all) tlb_v_d = '0;
      if (tlb_we) tlb_v_d[tlb_widx] = tlb_wv;
   end

   always_ff @(posedge clk) begin
      // NOTE: state uses non-blocking assignment so every flop samples pre-edge values.
      if (rst) begin
         resp_valid_q   <= 1'b0;
         resp_paddr_q   <= '0;
         resp_uncache_q <= 1'b0;
         resp_exc_q     <= EXC_NONE;
         miss_cnt_q     <= '0;
         tlb_v_q        <= '0;
      end else begin
         resp_valid_q   <= resp_valid_d;
         resp_paddr_q   <= resp_paddr_d;
         resp_uncache_q <= resp_uncache_d;
         resp_exc_q     <= resp_exc_d;
         miss_cnt_q     <= miss_cnt_d;
         tlb_v_q        <= tlb_v_d;
      end
   end

   // NOTE: entry payload has no reset; clearing the V bits alone makes every entry unusable.
   always_ff @(posedge clk) begin
      if (tlb_we) begin
         tlb_q[tlb_widx] <= '{vppn: tlb_wvppn, ppn: tlb_wppn, asid: tlb_wasid, g: tlb_wg,
                              d: tlb_wd, mat: tlb_wmat, plv: tlb_wplv};
      end
   end

   assign bus.resp_valid   = resp_valid_q;
   assign bus.resp_paddr   = resp_paddr_q;
   assign bus.resp_uncache = resp_uncache_q;
   assign bus.resp_exc     = resp_exc_q;
   assign perf_miss_cnt    = miss_cnt_q;
endmodule

// File: tb/tb_addr_trans_tlb.sv
// Bench for addr_trans_tlb: directed scenarios plus random traffic, scored through an
// expected-response queue filled from a behavioural translation model.
module tb_addr_trans_tlb;
   localparam int NE      = 8;
   localparam int CW      = 4;
   localparam int CNT_MAX = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   addr_trans_tlb_if bus ();

   logic          csr_da, csr_pg;
   logic [1:0]    csr_plv;
   logic [9:0]    csr_asid;
   logic [31:0]   csr_dmw0, csr_dmw1;
   logic          tlb_we, tlb_wg, tlb_wv, tlb_wd, tlb_inv_all;
   logic [2:0]    tlb_widx;
   logic [19:0]   tlb_wvppn, tlb_wppn;
   logic [9:0]    tlb_wasid;
   logic [1:0]    tlb_wmat, tlb_wplv;
   logic [CW-1:0] perf_miss_cnt;

   addr_trans_tlb #(.TLB_ENTRIES(NE), .UNCACHE_HI(16'hbfaf), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .csr_da(csr_da), .csr_pg(csr_pg), .csr_plv(csr_plv), .csr_asid(csr_asid),
      .csr_dmw0(csr_dmw0), .csr_dmw1(csr_dmw1),
      .tlb_we(tlb_we), .tlb_widx(tlb_widx), .tlb_wvppn(tlb_wvppn), .tlb_wppn(tlb_wppn),
      .tlb_wasid(tlb_wasid), .tlb_wg(tlb_wg), .tlb_wv(tlb_wv), .tlb_wd(tlb_wd),
      .tlb_wmat(tlb_wmat), .tlb_wplv(tlb_wplv), .tlb_inv_all(tlb_inv_all),
      .perf_miss_cnt(perf_miss_cnt)
   );

   typedef struct packed {
      logic [31:0] paddr;
      logic        unc;
      logic [2:0]  exc;
   } resp_t;

   typedef struct packed {
      logic [19:0] vppn;
      logic [19:0] ppn;
      logic [9:0]  asid;
      logic        g, v, d;
      logic [1:0]  mat, plv;
   } ent_t;

   ent_t  m_tlb [NE];
   int    m_cnt;
   resp_t exp_q [$];
   int    n_checks = 0;
   int    n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Translation rules applied directly to the model TLB and current CSR values.
   function automatic resp_t model_xlate(input logic [31:0] va, input logic st);
      resp_t       r;
      logic [31:0] dmw [2];
      int          idx;
      logic        mmio;
      mmio    = (va[31:16] == 16'hbfaf);
      r.paddr = va;
      r.unc   = 1'b0;
      r.exc   = 3'd0;
      dmw[0]  = csr_dmw0;
      dmw[1]  = csr_dmw1;
      if (csr_da || !csr_pg) begin
         r.unc = mmio;
         return r;
      end
      for (int w = 0; w < 2; w++) begin
         if (((dmw[w][0] && csr_plv == 2'd0) || (dmw[w][3] && csr_plv == 2'd3)) &&
             va[31:29] == dmw[w][31:29]) begin
            r.paddr = {dmw[w][27:25], va[28:0]};
            r.unc   = (dmw[w][5:4] == 2'd0) || mmio;
            return r;
         end
      end
      idx = -1;
      for (int i = 0; i < NE; i++)
         if (idx < 0 && m_tlb[i].vppn == va[31:12] && (m_tlb[i].g || m_tlb[i].asid == csr_asid))
            idx = i;
      if (idx < 0)                          r.exc = 3'd1;
      else if (!m_tlb[idx].v)               r.exc = 3'd2;
      else if (csr_plv > m_tlb[idx].plv)    r.exc = 3'd3;
      else if (st && !m_tlb[idx].d)         r.exc = 3'd4;
      else begin
         r.paddr = {m_tlb[idx].ppn, va[11:0]};
         r.unc   = (m_tlb[idx].mat == 2'd0) || mmio;
      end
      return r;
   endfunction

   // Called right after a falling edge once inputs are driven; returns at the next one.
   task automatic commit();
      resp_t r;
      #1;
      if (!rst) begin
         check("req_ready", 32'(bus.req_ready), 32'((exp_q.size() == 0) || bus.resp_ready));
         if (bus.req_valid && bus.req_ready) begin
            r = model_xlate(bus.req_vaddr, bus.req_store);
            exp_q.push_back(r);
            if (r.exc == 3'd1 && m_cnt < CNT_MAX) m_cnt++;
         end
         if (tlb_inv_all) for (int i = 0; i < NE; i++) m_tlb[i].v = 1'b0;
         if (tlb_we)
            m_tlb[tlb_widx] = '{vppn: tlb_wvppn, ppn: tlb_wppn, asid: tlb_wasid, g: tlb_wg,
                                v: tlb_wv, d: tlb_wd, mat: tlb_wmat, plv: tlb_wplv};
      end
      @(negedge clk);
      tlb_we      = 1'b0;
      tlb_inv_all = 1'b0;
   endtask

   task automatic set_write(input logic [2:0] idx, input logic [19:0] vppn, input logic [19:0] ppn,
                            input logic [9:0] asid, input logic g, input logic v, input logic d,
                            input logic [1:0] mat, input logic [1:0] plv);
      tlb_we = 1'b1; tlb_widx = idx; tlb_wvppn = vppn; tlb_wppn = ppn; tlb_wasid = asid;
      tlb_wg = g; tlb_wv = v; tlb_wd = d; tlb_wmat = mat; tlb_wplv = plv;
   endtask

   task automatic twrite(input logic [2:0] idx, input logic [19:0] vppn, input logic [19:0] ppn,
                         input logic [9:0] asid, input logic g, input logic v, input logic d,
                         input logic [1:0] mat, input logic [1:0] plv);
      set_write(idx, vppn, ppn, asid, g, v, d, mat, plv);
      bus.req_valid = 1'b0;
      commit();
   endtask

   task automatic req(input logic [31:0] va, input logic st);
      bus.req_valid = 1'b1;
      bus.req_vaddr = va;
      bus.req_store = st;
      commit();
   endtask

   task automatic idle();
      bus.req_valid = 1'b0;
      commit();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.req_valid  = 1'b0;
      bus.resp_ready = 1'b0;
      tlb_we         = 1'b0;
      tlb_inv_all    = 1'b0;
      commit();
      commit();
      exp_q.delete();
      m_cnt = 0;
      for (int i = 0; i < NE; i++) m_tlb[i].v = 1'b0;
      rst = 1'b0;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
      check({tag, "_resp_paddr"}, bus.resp_paddr, 32'd0);
      check({tag, "_resp_uncache"}, 32'(bus.resp_uncache), 32'd0);
      check({tag, "_resp_exc"}, 32'(bus.resp_exc), 32'd0);
      check({tag, "_perf_cnt"}, 32'(perf_miss_cnt), 32'd0);
   endtask

   task automatic drain();
      bus.req_valid  = 1'b0;
      bus.resp_ready = 1'b1;
      for (int k = 0; k < 10 && exp_q.size() > 0; k++) commit();
      check("drain_empty", 32'(exp_q.size()), 32'd0);
   endtask

   function automatic logic [19:0] rand_vppn();
      case ($urandom_range(0, 5))
         0:       return 20'h00100;
         1:       return 20'h00101;
         2:       return 20'h00400;
         3:       return 20'h00500;
         4:       return 20'hbfaf0;
         default: return 20'hbfaff;
      endcase
   endfunction

   function automatic logic [31:0] rand_vaddr();
      logic [31:0] r;
      r = $urandom;
      case ($urandom_range(0, 3))
         0, 1:    return {rand_vppn(), r[11:0]};
         2:       return {16'hbfaf, r[15:0]};
         default: return r;
      endcase
   endfunction

   // Monitor: one expected entry is retired for each transfer on the response side.
   initial begin
      resp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (!rst && bus.resp_valid && bus.resp_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_resp", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("resp_paddr", bus.resp_paddr, e.paddr);
               check("resp_uncache", 32'(bus.resp_uncache), 32'(e.unc));
               check("resp_exc", 32'(bus.resp_exc), 32'(e.exc));
            end
         end
      end
   end

   initial begin
      #200000;
      n_errors++;
      $display("FAIL watchdog: time limit reached, expected completion before it");
      $fatal(1, "watchdog");
   end

   initial begin
      csr_da = 1'b1; csr_pg = 1'b0; csr_plv = 2'd0; csr_asid = 10'd5;
      csr_dmw0 = '0; csr_dmw1 = '0;
      bus.req_valid = 1'b0; bus.req_vaddr = '0; bus.req_store = 1'b0; bus.resp_ready = 1'b0;
      tlb_we = 1'b0; tlb_inv_all = 1'b0; tlb_widx = '0; tlb_wvppn = '0; tlb_wppn = '0;
      tlb_wasid = '0; tlb_wg = 1'b0; tlb_wv = 1'b0; tlb_wd = 1'b0; tlb_wmat = '0; tlb_wplv = '0;
      m_cnt = 0;
      for (int i = 0; i < NE; i++) m_tlb[i] = '0;

      @(negedge clk);
      do_reset();
      check_idle_outputs("reset");
      bus.resp_ready = 1'b1;
      for (int i = 0; i < NE; i++) twrite(3'(i), 20'hfff00 + 20'(i), 20'h0, 10'd0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0);

      // Direct mode, MMIO window
      req(32'hbfaf_f020, 1'b0);

      // DMW0 hits, cached/uncached; PLV3 falls through to a TLB miss
      csr_da = 1'b0; csr_pg = 1'b1; csr_dmw0 = 32'h8000_0011;
      req(32'h8000_1234, 1'b0);
      csr_dmw0 = 32'h8000_0001;
      req(32'h8000_1234, 1'b0);
      csr_plv = 2'd3;
      req(32'h8000_1234, 1'b0);

      // TLB hit, PME on store, ASID mismatch, PPI
      csr_plv = 2'd0;
      twrite(3'd3, 20'h00400, 20'h12345, 10'd5, 1'b0, 1'b1, 1'b0, 2'd1, 2'd3);
      req(32'h0040_0abc, 1'b0);
      req(32'h0040_0abc, 1'b1);
      csr_asid = 10'd6;
      req(32'h0040_0abc, 1'b0);
      csr_asid = 10'd5;
      twrite(3'd4, 20'h00500, 20'h0abcd, 10'd5, 1'b0, 1'b1, 1'b1, 2'd2, 2'd0);
      csr_plv = 2'd3;
      req(32'h0050_0123, 1'b0);
      csr_plv = 2'd0;
      idle();

      // Backpressure: one accept, three stalled cycles, then back-to-back transfers
      bus.resp_ready = 1'b0;
      req(32'h0040_0100, 1'b0);
      for (int k = 0; k < 3; k++) req(32'h0040_0200, 1'b0);
      bus.resp_ready = 1'b1;
      req(32'h0040_0200, 1'b0);
      req(32'h0040_0300, 1'b1);
      req(32'h8000_0400, 1'b0);
      idle();
      idle();

      // Invalidate-all and write to the same index in one cycle
      for (int i = 0; i < 3; i++)
         twrite(3'(i), 20'h00100 + 20'(i), 20'h55500 + 20'(i), 10'd5, 1'b0, 1'b1, 1'b1, 2'd1, 2'd3);
      tlb_inv_all = 1'b1;
      twrite(3'd3, 20'h00400, 20'h12345, 10'd5, 1'b0, 1'b1, 1'b1, 2'd1, 2'd3);
      req(32'h0010_0010, 1'b0);
      req(32'h0010_1020, 1'b0);
      req(32'h0010_2030, 1'b0);
      req(32'h0040_0abc, 1'b1);
      idle();

      // Randomized traffic with concurrent TLB maintenance and CSR changes
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 9) == 0) begin
            csr_da   = ($urandom_range(0, 3) == 0);
            csr_pg   = ($urandom_range(0, 3) != 0);
            csr_plv  = 2'($urandom_range(0, 3));
            csr_asid = 10'($urandom_range(5, 6));
            csr_dmw0 = $urandom & 32'hee00_0039;
            csr_dmw1 = $urandom & 32'hee00_0039;
         end
         if ($urandom_range(0, 7) == 0)
            set_write(3'($urandom_range(0, NE - 1)), rand_vppn(), 20'($urandom),
                      10'($urandom_range(5, 6)), 1'($urandom), 1'($urandom), 1'($urandom),
                      2'($urandom), 2'($urandom));
         if ($urandom_range(0, 31) == 0) tlb_inv_all = 1'b1;
         bus.resp_ready = ($urandom_range(0, 3) != 0);
         bus.req_valid  = ($urandom_range(0, 3) != 0);
         bus.req_vaddr  = rand_vaddr();
         bus.req_store  = 1'($urandom);
         commit();
      end
      drain();
      check("perf_cnt_random", 32'(perf_miss_cnt), 32'(m_cnt));

      // Miss counter saturation, then reset with a response in flight
      csr_da = 1'b0; csr_pg = 1'b1; csr_plv = 2'd0; csr_asid = 10'd7;
      csr_dmw0 = '0; csr_dmw1 = '0;
      bus.resp_ready = 1'b1;
      for (int k = 0; k < 20; k++) req({20'hdead0, 12'(k * 4)}, 1'b0);
      idle();
      check("perf_cnt_model", 32'(perf_miss_cnt), 32'(m_cnt));
      check("perf_cnt_saturated", 32'(perf_miss_cnt), 32'hf);
      bus.resp_ready = 1'b0;
      csr_asid = 10'd5;
      req(32'h0040_0abc, 1'b0);
      do_reset();
      check_idle_outputs("midreset");
      bus.resp_ready = 1'b1;
      req(32'h0040_0abc, 1'b0);
      req(32'h0010_0010, 1'b0);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
